fetch_unit: RTL and testbench

Instruction-fetch front end and the consumer of the EX-stage branch outputs (br_ctrl, br_pc).
- Generates sequential PCs and issues requests over a valid/ready instruction-memory port.
- Buffers in-order responses with their PCs in a small FIFO and presents them to ID under a ready/valid stall handshake.
- On an EX-stage redirect, flushes the buffer, discards stale in-flight responses and restarts fetch at the branch target.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, in-order response buffering,
// and redirect handling that flushes buffered words and discards stale in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_ctrl,
  input  logic [31:0] br_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [31:0]      NOP     = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      hold_pc_q;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      pc_mem   [FIFO_DEPTH];
  logic [31:0]      inst_mem [FIFO_DEPTH];

  logic             req_fire;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;

  // In-flight plus buffered words never exceed the buffer, so a push can never overflow.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !br_ctrl && (occupancy < {1'b0, DEPTH_C});
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr_q]   : hold_pc_q;
  assign if_inst  = if_valid ? inst_mem[rd_ptr_q] : NOP;

  assign push = imem_resp_valid && !br_ctrl && (discard_q == '0);
  assign pop  = if_valid && id_ready && !br_ctrl;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (req_fire && !imem_resp_valid) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!req_fire && imem_resp_valid) begin
      inflight_d = inflight_q - CNT_ONE;
    end

    if (br_ctrl) begin
      // Every request still outstanding after this cycle belongs to the old path.
      pc_d      = word_align(br_pc);
      resp_pc_d = word_align(br_pc);
      discard_d = imem_resp_valid ? (inflight_q - CNT_ONE) : inflight_q;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_resp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_ONE;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      hold_pc_q  <= 32'h0000_0000;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      hold_pc_q  <= if_pc;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage carries data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      inst_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

  resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight_q != '0));
  discard_bounded: assert property (@(posedge clk) disable iff (rst)
    discard_q <= inflight_q);
  occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
    occupancy <= {1'b0, DEPTH_C});

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level memory and program-order model
// predicts every word delivered to ID; directed phases plus a randomized phase.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_ctrl = 1'b0;
  logic [31:0] br_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .br_ctrl(br_ctrl), .br_pc(br_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } item_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  item_t       exp_q[$];
  mreq_t       mq[$];
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] last_seen_pc = '0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          req_cnt = 0;
  int          m_due;
  bit          just_br = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (just_br) chk("valid_after_redirect", {31'd0, if_valid}, 32'd0);
      just_br = 1'b0;
      if (br_ctrl) chk("req_valid_on_redirect", {31'd0, imem_req_valid}, 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        m_due = cyc + $urandom_range(lat_max, lat_min);
        if (m_due <= last_due) m_due = last_due + 1;
        last_due = m_due;
        mq.push_back('{addr: imem_req_addr, due: m_due});
        req_cnt++;
        if (!br_ctrl) begin
          chk("req_addr", imem_req_addr, model_pc);
          exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
      if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_if_valid", {31'd0, if_valid}, 32'd0);
        end else begin
          chk("if_pc", if_pc, exp_q[0].pc);
          chk("if_inst", if_inst, exp_q[0].inst);
          if (id_ready && !br_ctrl) void'(exp_q.pop_front());
        end
        last_seen_pc = if_pc;
      end else begin
        chk("empty_nop", if_inst, NOP);
        chk("empty_pc_hold", if_pc, last_seen_pc);
      end
      if (br_ctrl) begin
        exp_q.delete();
        model_pc = br_pc & 32'hFFFF_FFFC;
        just_br  = 1'b1;
      end
    end
  end

  task automatic drive_resp();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic step(input bit rdy, input bit idr, input bit br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    imem_req_ready = rdy;
    id_ready       = idr;
    br_ctrl        = br;
    br_pc          = tgt;
    drive_resp();
  endtask

  task automatic run(input int n, input bit rdy, input bit idr);
    for (int i = 0; i < n; i++) step(rdy, idr, 1'b0, 32'h0);
  endtask

  // Asserts reset immediately, checks the asynchronous effect, then releases
  // it so that the cycle after the release edge is cycle 0 of the new run.
  task automatic do_reset(input bit rdy, input bit idr);
    rst = 1'b1;
    br_ctrl = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; id_ready = 1'b0;
    mq.delete(); exp_q.delete();
    model_pc = RESET_PC; last_seen_pc = '0; last_due = 0; just_br = 1'b0; req_cnt = 0;
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_if_pc", if_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    imem_req_ready = rdy;
    id_ready = idr;
  endtask

  initial begin
    // Test 1: streaming from reset, 1-cycle memory.
    lat_min = 1; lat_max = 1;
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    chk("t1_req_valid_c0", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req_addr_c0", imem_req_addr, RESET_PC);
    chk("t1_if_valid_c0", {31'd0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_if_valid_c1", {31'd0, if_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_if_valid_c2", {31'd0, if_valid}, 32'd1);
    chk("t1_if_pc_c2", if_pc, RESET_PC);
    run(10, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_one_per_cycle", if_pc, RESET_PC + 32'd40);

    // Test 2: ID stalled, occupancy cap of 4, then drain and resume.
    do_reset(1'b1, 1'b0);
    run(9, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_req_count", req_cnt, 32'd4);
    chk("t2_req_blocked", {31'd0, imem_req_valid}, 32'd0);
    chk("t2_head_pc", if_pc, 32'h0);
    run(12, 1'b1, 1'b1);

    // Test 3: 3-cycle memory, redirect with requests outstanding.
    lat_min = 3; lat_max = 3;
    do_reset(1'b1, 1'b1);
    run(2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_req_valid_r1", {31'd0, imem_req_valid}, 32'd1);
    chk("t3_req_addr_r1", imem_req_addr, 32'h0000_0100);
    run(12, 1'b1, 1'b1);

    // Test 4: redirect coinciding with a pop and a live response.
    lat_min = 1; lat_max = 1;
    run(6, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    @(negedge clk);
    chk("t4_if_valid_at_r", {31'd0, if_valid}, 32'd1);
    chk("t4_resp_at_r", {31'd0, imem_resp_valid}, 32'd1);
    run(8, 1'b1, 1'b1);

    // Test 5: second redirect while the first target's requests are outstanding.
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    run(1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    run(15, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_stream_pc", if_pc[31:8], 32'h0000_0003);

    // Randomized traffic: variable latency, back-pressure, stalls, redirects (some unaligned or wrapping).
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom % 2 == 0) ? $urandom : (32'hFFFF_FFF0 + ($urandom % 16));
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, tgt);
    end
    run(24, 1'b0, 1'b1);
    @(negedge clk);
    chk("drain_expected_empty", exp_q.size(), 32'd0);
    chk("drain_if_valid", {31'd0, if_valid}, 32'd0);

    // Test 6: asynchronous reset with a full buffer, then restart at RESET_PC.
    lat_min = 1; lat_max = 1;
    run(10, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_full_valid", {31'd0, if_valid}, 32'd1);
    chk("t6_full_blocked", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #3;
    do_reset(1'b1, 1'b1);
    @(negedge clk);
    chk("t6_restart_addr", imem_req_addr, RESET_PC);
    run(10, 1'b1, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
